// File: rtl/serial_tx.sv
// Framed parallel-in/serial-out transmitter: start(0), data LSB first, optional even parity, stop(1).
// Define TX_PARITY_EN to insert the parity bit between the data bits and the stop bit.
module serial_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  tx_busy
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW  = $clog2(DATA_WIDTH + 1);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                state_q, state_d;
  logic [BaudW-1:0]      baud_q, baud_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  serial_q, serial_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  baud_wrap;
`ifdef TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign baud_wrap = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
`ifdef TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tx_valid && ready_q) begin
          state_d  = StStart;
          shift_d  = tx_data;
`ifdef TX_PARITY_EN
          parity_d = ^tx_data;
`endif
          serial_d = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          baud_d   = '0;
          bit_d    = '0;
        end
      end
      StStart: begin
        if (baud_wrap) begin
          baud_d   = '0;
          state_d  = StData;
          serial_d = shift_q[0];
          shift_d  = shift_q >> 1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == BitLast) begin
            bit_d    = '0;
`ifdef TX_PARITY_EN
            state_d  = StParity;
            serial_d = parity_q;
`else
            state_d  = StStop;
            serial_d = 1'b1;
`endif
          end else begin
            bit_d    = bit_q + 1'b1;
            serial_d = shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef TX_PARITY_EN
      StParity: begin
        if (baud_wrap) begin
          baud_d   = '0;
          state_d  = StStop;
          serial_d = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = StIdle;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        serial_d = 1'b1;
        ready_d  = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_ready  = ready_q;
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one instance at 4 clocks/bit, one at 1 clock/bit, checked cycle by cycle
// against a frame model built from the framing rules.
module tb_serial_tx;

  localparam int DW = 8;
`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = DW + 2 + PAR;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b, serial_a, serial_b, busy_a, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(4)) u_dut4 (
    .clock(clk), .reset_n(rst_n), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx_serial(serial_a), .tx_busy(busy_a)
  );

  serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx_serial(serial_b), .tx_busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ready_a : ready_b;
  endfunction
  function automatic logic get_serial(input int sel);
    return (sel == 0) ? serial_a : serial_b;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel == 0) valid_a = v; else valid_b = v;
  endtask
  task automatic set_data(input int sel, input logic [7:0] d);
    if (sel == 0) data_a = d; else data_b = d;
  endtask

  // Line level for bit slot idx of a frame carrying d.
  function automatic logic model_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return d[idx-1];
    if (PAR == 1 && idx == DW + 1) return ^d;
    return 1'b1;
  endfunction

  task automatic check_idle(input int sel, input string tag);
    check({tag, "_ready"}, get_ready(sel), 1);
    check({tag, "_busy"}, get_busy(sel), 0);
    check({tag, "_line"}, get_serial(sel), 1);
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic ep, input bit hold,
                            input int poke_at, input int rst_at);
    int   cpb;
    int   guard;
    int   idx;
    logic eb;
    cpb   = (sel == 0) ? 4 : 1;
    guard = 0;
    while (!get_ready(sel) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", get_ready(sel), 1);
    if (!get_ready(sel)) return;
    set_data(sel, d);
    set_valid(sel, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_valid(sel, 1'b0);
    for (int k = 0; k < FL * cpb; k++) begin
      @(negedge clk);
      idx = k / cpb;
      if (PAR == 1 && idx == DW + 1) eb = ep;
      else eb = model_bit(d, idx);
      check("line", get_serial(sel), eb);
      check("ready_low", get_ready(sel), 0);
      check("busy_high", get_busy(sel), 1);
      if (k == poke_at) begin
        set_data(sel, ~d);
        set_valid(sel, 1'b1);
        @(posedge clk);
        #1;
        set_valid(sel, 1'b0);
      end
      if (k == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_idle(sel, "abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(sel, "post_abort");
        return;
      end
    end
    @(negedge clk);
    check_idle(sel, "frame_end");
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{data: 8'hA5, par: 1'b0};
    tbl[1] = '{data: 8'h07, par: 1'b1};
    tbl[2] = '{data: 8'h00, par: 1'b0};
    tbl[3] = '{data: 8'h80, par: 1'b1};
    tbl[4] = '{data: 8'h3C, par: 1'b0};

    rst_n   = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = 8'h00;
    data_b  = 8'h00;

    // Asynchronous reset before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    check_idle(0, "reset4");
    check_idle(1, "reset1");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "released");

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      send_frame(0, tbl[i].data, tbl[i].par, 1'b0, -1, -1);
      @(negedge clk);
    end

    // tx_valid held: exactly one idle cycle between frames.
    send_frame(0, 8'h01, 1'b1, 1'b1, -1, -1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, -1, -1);

    // Mid-frame data change and valid pulse are ignored.
    send_frame(0, 8'h5A, 1'b0, 1'b0, 13, -1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_second_frame", get_busy(0), 0);
    end

    // Reset during data bit 3, then a clean frame.
    send_frame(0, 8'h3C, 1'b0, 1'b0, -1, 4 * 4 + 1);
    send_frame(0, 8'hC3, 1'b0, 1'b0, -1, -1);

    // One clock per bit.
    send_frame(1, 8'hA5, 1'b0, 1'b0, -1, -1);
    send_frame(1, 8'h96, 1'b0, 1'b0, -1, 4);
    send_frame(1, 8'h96, 1'b0, 1'b0, -1, -1);
    send_frame(1, 8'h01, 1'b1, 1'b1, -1, -1);
    send_frame(1, 8'hFE, 1'b1, 1'b0, -1, -1);

    // Random words against the model.
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      int         sel;
      int         gap;
      d   = 8'($urandom);
      sel = (i % 3 == 0) ? 1 : 0;
      gap = $urandom_range(0, 3);
      send_frame(sel, d, ^d, 1'b0, -1, -1);
      for (int g = 0; g < gap; g++) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
